i2c_fifo: RTL and testbench

- Word-buffering stage between the I2C slave PHY and the CPU/register side of the superkdf9 I2C component.
- RX path: 32-bit words pushed by the PHY after each 4-byte write are queued for the CPU.
- TX path: the CPU queues 32-bit words, and the PHY pops them when a master reads.
- Also generates full/empty back-pressure flags for the PHY, level counters, sticky error flags and a single interrupt.

---
 rtl/i2c_fifo_pkg.sv | 11 +
 rtl/i2c_fifo_fwft.sv | 62 ++++++
 rtl/i2c_fifo.sv | 84 ++++++++
 tb/tb_i2c_fifo.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/i2c_fifo_pkg.sv
// Shared bit indices for the i2c_fifo interrupt status and error flag vectors.
package i2c_fifo_pkg;
  localparam int IRQ_RXTHR  = 0;
  localparam int IRQ_WSTOP  = 1;
  localparam int IRQ_RSTOP  = 2;
  localparam int IRQ_ERR    = 3;

  localparam int ERR_RX_OVF = 0;
  localparam int ERR_TX_OVF = 1;
  localparam int ERR_UDF    = 2;
endpackage

// File: rtl/i2c_fifo_fwft.sv
// Circular-buffer FIFO with first-word-fall-through head and per-cycle
// overflow/underflow event pulses.
module i2c_fifo_fwft #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  input  logic          clr,
  output logic [DW-1:0] dout,
  output logic [AW:0]   cnt,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          udf
);
  localparam int         DEPTH_I = 1 << AW;
  localparam logic [AW:0] DEPTH  = (AW+1)'(DEPTH_I);

  logic [DW-1:0] mem [DEPTH_I];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign full  = (cnt == DEPTH);
  assign empty = (cnt == '0);

  // A pop frees a slot in the same edge, so push-while-full is fine if popping.
  assign push_ok = push & ~clr & (~full | pop);
  assign pop_ok  = pop  & ~clr & ~empty;
  assign ovf     = push & ~clr & full & ~pop;
  assign udf     = pop  & ~clr & empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];
endmodule

// File: rtl/i2c_fifo.sv
// RX/TX word buffering between the I2C slave PHY and the CPU side, with
// level counters, sticky error flags and a single registered interrupt.
module i2c_fifo
  import i2c_fifo_pkg::*;
#(
  parameter int AW     = 4,
  parameter int DW     = 32,
  parameter int RX_THR = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          phy_push,
  input  logic [DW-1:0] phy_dout,
  output logic          phy_full,
  input  logic          phy_pop,
  output logic [DW-1:0] phy_din,
  output logic          phy_empty,
  input  logic          phy_wstop,
  input  logic          phy_rstop,
  input  logic          phy_rerr,
  input  logic          cpu_rd,
  output logic [DW-1:0] cpu_rdata,
  input  logic          cpu_wr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          clr_rx,
  input  logic          clr_tx,
  output logic [AW:0]   rx_cnt,
  output logic [AW:0]   tx_cnt,
  input  logic [3:0]    irq_en,
  input  logic [3:0]    irq_ack,
  output logic [3:0]    irq_stat,
  output logic [2:0]    err_flags,
  output logic          irq
);
  logic       rx_empty, tx_full;
  logic       rx_ovf, rx_udf, tx_ovf, tx_udf;
  logic [2:0] err_set;
  logic [3:0] sticky_set, sticky;

  i2c_fifo_fwft #(.AW(AW), .DW(DW)) u_rx (
    .clk(clk), .rst_n(rst_n),
    .push(phy_push), .din(phy_dout), .pop(cpu_rd), .clr(clr_rx),
    .dout(cpu_rdata), .cnt(rx_cnt), .full(phy_full), .empty(rx_empty),
    .ovf(rx_ovf), .udf(rx_udf)
  );

  i2c_fifo_fwft #(.AW(AW), .DW(DW)) u_tx (
    .clk(clk), .rst_n(rst_n),
    .push(cpu_wr), .din(cpu_wdata), .pop(phy_pop), .clr(clr_tx),
    .dout(phy_din), .cnt(tx_cnt), .full(tx_full), .empty(phy_empty),
    .ovf(tx_ovf), .udf(tx_udf)
  );

  always_comb begin
    err_set             = '0;
    err_set[ERR_RX_OVF] = rx_ovf;
    err_set[ERR_TX_OVF] = tx_ovf;
    err_set[ERR_UDF]    = rx_udf | tx_udf;

    sticky_set            = '0;
    sticky_set[IRQ_WSTOP] = phy_wstop;
    sticky_set[IRQ_RSTOP] = phy_rstop;
    sticky_set[IRQ_ERR]   = phy_rerr | (|err_set);
  end

  // Set beats ack; bit 0 is the level source and never latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky    <= '0;
      err_flags <= '0;
      irq       <= 1'b0;
    end else begin
      sticky    <= ((sticky & ~irq_ack) | sticky_set) & 4'b1110;
      err_flags <= (err_flags & ~{3{irq_ack[IRQ_ERR]}}) | err_set;
      irq       <= |(irq_stat & irq_en);
    end
  end

  assign irq_stat = sticky | {3'b000, (rx_cnt >= (AW+1)'(RX_THR))};

  // Full/empty of the unobserved sides feed no port; fold them into nothing.
  logic unused_flags;
  assign unused_flags = rx_empty ^ tx_full;
endmodule

// File: tb/tb_i2c_fifo.sv
// Directed self-checking bench for i2c_fifo (AW=4, DW=32, RX_THR=8).
module tb_i2c_fifo;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        phy_push, phy_pop, phy_wstop, phy_rstop, phy_rerr;
  logic [31:0] phy_dout, cpu_wdata;
  logic        cpu_rd, cpu_wr, clr_rx, clr_tx;
  logic [3:0]  irq_en, irq_ack;
  logic        phy_full, phy_empty, irq;
  logic [31:0] phy_din, cpu_rdata;
  logic [4:0]  rx_cnt, tx_cnt;
  logic [3:0]  irq_stat;
  logic [2:0]  err_flags;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  i2c_fifo #(.AW(4), .DW(32), .RX_THR(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .phy_push(phy_push), .phy_dout(phy_dout), .phy_full(phy_full),
    .phy_pop(phy_pop), .phy_din(phy_din), .phy_empty(phy_empty),
    .phy_wstop(phy_wstop), .phy_rstop(phy_rstop), .phy_rerr(phy_rerr),
    .cpu_rd(cpu_rd), .cpu_rdata(cpu_rdata),
    .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .clr_rx(clr_rx), .clr_tx(clr_tx),
    .rx_cnt(rx_cnt), .tx_cnt(tx_cnt),
    .irq_en(irq_en), .irq_ack(irq_ack), .irq_stat(irq_stat),
    .err_flags(err_flags), .irq(irq)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    phy_push = 0; phy_pop = 0; phy_wstop = 0; phy_rstop = 0; phy_rerr = 0;
    cpu_rd = 0; cpu_wr = 0; clr_rx = 0; clr_tx = 0; irq_ack = 0;
  endtask

  task automatic push_rx(input logic [31:0] w);
    phy_push = 1; phy_dout = w; tick(); phy_push = 0;
  endtask

  task automatic test_reset();
    idle(); irq_en = 0; phy_dout = 0; cpu_wdata = 0;
    rst_n = 0; #12;
    vectors++; if (rx_cnt !== 5'd0) begin miscompares++; $display("FAIL reset_rx_cnt got %0d want 0", rx_cnt); end
    vectors++; if (tx_cnt !== 5'd0) begin miscompares++; $display("FAIL reset_tx_cnt got %0d want 0", tx_cnt); end
    vectors++; if ({phy_empty, phy_full} !== 2'b10) begin miscompares++; $display("FAIL reset_flags got empty=%b full=%b want 1/0", phy_empty, phy_full); end
    vectors++; if ({irq_stat, err_flags, irq} !== 8'h00) begin miscompares++; $display("FAIL reset_irq got stat=%b err=%b irq=%b want 0", irq_stat, err_flags, irq); end
    @(negedge clk); rst_n = 1; tick();
  endtask

  task automatic test_rx_order();
    logic [31:0] exp;
    push_rx(32'h11111111);
    vectors++; if (cpu_rdata !== 32'h11111111) begin miscompares++; $display("FAIL rx_fwft got %h want 11111111", cpu_rdata); end
    push_rx(32'h22222222); push_rx(32'h33333333); push_rx(32'h44444444);
    vectors++; if (rx_cnt !== 5'd4) begin miscompares++; $display("FAIL rx_cnt4 got %0d want 4", rx_cnt); end
    for (int i = 1; i <= 4; i++) begin
      exp = 32'h11111111 * i;
      vectors++; if (cpu_rdata !== exp) begin miscompares++; $display("FAIL rx_order%0d got %h want %h", i, cpu_rdata, exp); end
      cpu_rd = 1; tick(); cpu_rd = 0;
    end
    vectors++; if (rx_cnt !== 5'd0) begin miscompares++; $display("FAIL rx_drain got %0d want 0", rx_cnt); end
  endtask

  task automatic test_tx_fwft();
    cpu_wr = 1; cpu_wdata = 32'hDEADBEEF; tick(); cpu_wr = 0;
    vectors++; if (phy_empty !== 1'b0) begin miscompares++; $display("FAIL tx_not_empty got %b want 0", phy_empty); end
    vectors++; if (phy_din !== 32'hDEADBEEF) begin miscompares++; $display("FAIL tx_head got %h want deadbeef", phy_din); end
    phy_pop = 1; tick(); phy_pop = 0;
    vectors++; if ({phy_empty, tx_cnt} !== {1'b1, 5'd0}) begin miscompares++; $display("FAIL tx_pop got empty=%b cnt=%0d want 1/0", phy_empty, tx_cnt); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) push_rx(32'hA0000000 + i);
    vectors++; if ({phy_full, rx_cnt} !== {1'b1, 5'd16}) begin miscompares++; $display("FAIL ovf_full got full=%b cnt=%0d want 1/16", phy_full, rx_cnt); end
    vectors++; if (err_flags !== 3'b000) begin miscompares++; $display("FAIL ovf_pre_err got %b want 000", err_flags); end
    push_rx(32'h0BAD0BAD);
    vectors++; if (rx_cnt !== 5'd16) begin miscompares++; $display("FAIL ovf_cnt got %0d want 16", rx_cnt); end
    vectors++; if (err_flags !== 3'b001) begin miscompares++; $display("FAIL ovf_err got %b want 001", err_flags); end
    vectors++; if (irq_stat !== 4'b1001) begin miscompares++; $display("FAIL ovf_stat got %b want 1001", irq_stat); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL ovf_irq_masked got %b want 0", irq); end
    irq_ack = 4'b1000; tick(); irq_ack = 0;
    vectors++; if ({irq_stat, err_flags} !== {4'b0001, 3'b000}) begin miscompares++; $display("FAIL ovf_ack got stat=%b err=%b want 0001/000", irq_stat, err_flags); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp;
    phy_push = 1; phy_dout = 32'hC0000010; cpu_rd = 1; tick(); phy_push = 0; cpu_rd = 0;
    vectors++; if ({rx_cnt, err_flags} !== {5'd16, 3'b000}) begin miscompares++; $display("FAIL fpp_cnt got cnt=%0d err=%b want 16/000", rx_cnt, err_flags); end
    for (int i = 1; i <= 16; i++) begin
      exp = (i == 16) ? 32'hC0000010 : 32'hA0000000 + i;
      vectors++; if (cpu_rdata !== exp) begin miscompares++; $display("FAIL fpp_wrap%0d got %h want %h", i, cpu_rdata, exp); end
      cpu_rd = 1; tick(); cpu_rd = 0;
    end
    vectors++; if ({phy_full, rx_cnt} !== {1'b0, 5'd0}) begin miscompares++; $display("FAIL fpp_drain got full=%b cnt=%0d want 0/0", phy_full, rx_cnt); end
  endtask

  task automatic test_irq_thr();
    irq_en = 4'b0001;
    for (int i = 0; i < 7; i++) push_rx(32'h50 + i);
    vectors++; if ({irq_stat[0], irq} !== 2'b00) begin miscompares++; $display("FAIL thr7 got stat0=%b irq=%b want 00", irq_stat[0], irq); end
    push_rx(32'h57);
    vectors++; if ({irq_stat[0], irq} !== 2'b10) begin miscompares++; $display("FAIL thr8 got stat0=%b irq=%b want 10", irq_stat[0], irq); end
    tick();
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL thr_irq got %b want 1", irq); end
    cpu_rd = 1; tick(); cpu_rd = 0;
    vectors++; if ({irq_stat[0], irq} !== 2'b01) begin miscompares++; $display("FAIL thr_drop got stat0=%b irq=%b want 01", irq_stat[0], irq); end
    tick();
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL thr_irq_low got %b want 0", irq); end
    clr_rx = 1; phy_push = 1; phy_dout = 32'h99; tick(); clr_rx = 0; phy_push = 0;
    vectors++; if ({rx_cnt, err_flags} !== {5'd0, 3'b000}) begin miscompares++; $display("FAIL clr_pri got cnt=%0d err=%b want 0/000", rx_cnt, err_flags); end
    irq_en = 0;
  endtask

  task automatic test_underflow();
    cpu_rd = 1; tick(); cpu_rd = 0;
    vectors++; if ({err_flags, irq_stat[3], rx_cnt} !== {3'b100, 1'b1, 5'd0}) begin miscompares++; $display("FAIL udf_rx got err=%b stat3=%b cnt=%0d want 100/1/0", err_flags, irq_stat[3], rx_cnt); end
    irq_ack = 4'b1000; tick(); irq_ack = 0;
    cpu_wr = 1; cpu_wdata = 32'h12345678; phy_pop = 1; tick(); cpu_wr = 0; phy_pop = 0;
    vectors++; if ({tx_cnt, err_flags} !== {5'd1, 3'b100}) begin miscompares++; $display("FAIL udf_tx got cnt=%0d err=%b want 1/100", tx_cnt, err_flags); end
    vectors++; if (phy_din !== 32'h12345678) begin miscompares++; $display("FAIL udf_tx_head got %h want 12345678", phy_din); end
    irq_ack = 4'b1000; tick(); irq_ack = 0;
  endtask

  task automatic test_reset_midburst();
    cpu_wr = 1; cpu_wdata = 32'h2; tick(); cpu_wdata = 32'h3; tick(); cpu_wr = 0;
    vectors++; if (tx_cnt !== 5'd3) begin miscompares++; $display("FAIL mid_pre got %0d want 3", tx_cnt); end
    phy_pop = 1; #2; rst_n = 0; #1;
    vectors++; if ({tx_cnt, phy_empty} !== {5'd0, 1'b1}) begin miscompares++; $display("FAIL mid_rst got cnt=%0d empty=%b want 0/1", tx_cnt, phy_empty); end
    phy_pop = 0; @(negedge clk); rst_n = 1; tick();
    phy_wstop = 1; irq_ack = 4'b0010; tick(); phy_wstop = 0; irq_ack = 0;
    vectors++; if (irq_stat !== 4'b0010) begin miscompares++; $display("FAIL wstop_ack got %b want 0010", irq_stat); end
    irq_en = 4'b0100; phy_rstop = 1; tick(); phy_rstop = 0;
    vectors++; if ({irq_stat, irq} !== {4'b0110, 1'b0}) begin miscompares++; $display("FAIL rstop got stat=%b irq=%b want 0110/0", irq_stat, irq); end
    irq_ack = 4'b0110; tick(); irq_ack = 0;
    vectors++; if ({irq_stat, irq} !== {4'b0000, 1'b1}) begin miscompares++; $display("FAIL rstop_ack got stat=%b irq=%b want 0000/1", irq_stat, irq); end
    phy_rerr = 1; tick(); phy_rerr = 0;
    vectors++; if ({irq_stat, err_flags} !== {4'b1000, 3'b000}) begin miscompares++; $display("FAIL rerr got stat=%b err=%b want 1000/000", irq_stat, err_flags); end
  endtask

  initial begin
    test_reset();
    test_rx_order();
    test_tx_fwft();
    test_overflow();
    test_full_push_pop();
    test_irq_thr();
    test_underflow();
    test_reset_midburst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
